// File: rtl/sim_ctrl_seq_pkg.sv
// Shared types and defaults for the staggered-reset simulation controller.
// rel_f gives the cycle count at which a channel leaves its initial reset.
package sim_ctrl_seq_pkg;

  localparam int CHANNELS_DEF  = 4;
  localparam int CNT_W_DEF     = 32;
  localparam int RST_BASE_DEF  = 5;
  localparam int RST_STEP_DEF  = 2;
  localparam int SOFT_LEN_DEF  = 3;
  localparam int WDOG_W_DEF    = 8;
  localparam int DRAIN_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_FINISH  = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_WDOG    = 2'd3
  } cause_e;

  function automatic longint rel_f(input int i,
                                   input int base = RST_BASE_DEF,
                                   input int step = RST_STEP_DEF);
    return longint'(base) + longint'(i) * longint'(step);
  endfunction

endpackage

// File: rtl/sim_ctrl_seq_chan.sv
// One reset/watchdog channel: initial release compare, soft-reset pulse
// stretcher and a saturating heartbeat watchdog with a sticky error.
module sim_ctrl_seq_chan
  import sim_ctrl_seq_pkg::*;
#(
  parameter int IDX      = 0,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RST_BASE = RST_BASE_DEF,
  parameter int RST_STEP = RST_STEP_DEF,
  parameter int SOFT_LEN = SOFT_LEN_DEF,
  parameter int WDOG_W   = WDOG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_reset,
  input  logic              in_run,
  input  logic              in_active,
  input  logic [CNT_W-1:0]  cycles_nxt,
  input  logic              soft_req,
  input  logic              hbeat,
  input  logic [WDOG_W-1:0] wdog_lim,
  output logic              rst,
  output logic              wdog_err,
  output logic              err_set
);

  localparam int SW = $clog2(SOFT_LEN + 1);
  localparam logic [CNT_W-1:0] REL = CNT_W'(rel_f(IDX, RST_BASE, RST_STEP));
  localparam logic [SW-1:0] SOFT_INIT = SW'(SOFT_LEN);

  logic [SW-1:0]     scnt;
  logic [WDOG_W-1:0] wcnt;
  logic [WDOG_W-1:0] wcnt_nxt;
  logic              hit;

  // A channel held in reset (initial or soft) counts as alive.
  always_comb begin
    wcnt_nxt = wcnt;
    if (rst || hbeat) begin
      wcnt_nxt = '0;
    end else if (!(&wcnt)) begin
      wcnt_nxt = wcnt + WDOG_W'(1);
    end
  end

  assign hit     = (wdog_lim != '0) && (wcnt_nxt == wdog_lim);
  assign err_set = in_run && hit && !wdog_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst      <= 1'b1;
      scnt     <= '0;
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (in_reset) begin
        rst <= (cycles_nxt < REL);
      end else if (in_active) begin
        // scnt holds the number of reset cycles still owed, including this one.
        if (soft_req) begin
          scnt <= SOFT_INIT;
          rst  <= 1'b1;
        end else if (scnt != '0) begin
          scnt <= scnt - SW'(1);
          rst  <= (scnt != SW'(1));
        end
      end

      if (in_run) begin
        wcnt <= wcnt_nxt;
        if (hit) begin
          wdog_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sim_ctrl_seq.sv
// Simulation controller: staggered per-channel resets, saturating cycle
// counter, and a RESET/RUN/DRAIN/DONE sequencer that raises finish.
module sim_ctrl_seq
  import sim_ctrl_seq_pkg::*;
#(
  parameter int CHANNELS  = CHANNELS_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RST_BASE  = RST_BASE_DEF,
  parameter int RST_STEP  = RST_STEP_DEF,
  parameter int SOFT_LEN  = SOFT_LEN_DEF,
  parameter int WDOG_W    = WDOG_W_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic                sim_ctrl_seq_clk_ip,
  input  logic                sim_ctrl_seq_rst_n_ip,
  input  logic [CNT_W-1:0]    sim_ctrl_seq_timeout_ip,
  input  logic [WDOG_W-1:0]   sim_ctrl_seq_wdog_lim_ip,
  input  logic [CHANNELS-1:0] sim_ctrl_seq_soft_rst_ip,
  input  logic [CHANNELS-1:0] sim_ctrl_seq_hbeat_ip,
  input  logic                sim_ctrl_seq_finish_req_ip,
  output logic [CHANNELS-1:0] sim_ctrl_seq_rst_op,
  output logic [CNT_W-1:0]    sim_ctrl_seq_cycles_op,
  output logic [CHANNELS-1:0] sim_ctrl_seq_wdog_err_op,
  output logic [1:0]          sim_ctrl_seq_state_op,
  output logic [1:0]          sim_ctrl_seq_cause_op,
  output logic                sim_ctrl_seq_finish_op
);

  localparam longint REL_LAST_L = rel_f(CHANNELS - 1, RST_BASE, RST_STEP);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_LAST_L);
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  if ((CHANNELS < 1) || (CHANNELS > 32) || (SOFT_LEN < 1) || (DRAIN_CYC < 1) ||
      ((CNT_W < 63) && (REL_LAST_L >= (longint'(1) << CNT_W)))) begin : g_bad_params
    $error("sim_ctrl_seq: parameter out of range or last release beyond counter");
  end

  state_e             state;
  cause_e             cause;
  logic               finish;
  logic [CNT_W-1:0]   cycles;
  logic [CNT_W-1:0]   cycles_nxt;
  logic [DW-1:0]      dcnt;
  logic               pend;
  logic               in_reset;
  logic               in_run;
  logic               in_active;
  logic [CHANNELS-1:0] rst_vec;
  logic [CHANNELS-1:0] err_vec;
  logic [CHANNELS-1:0] err_set_vec;
  logic               wdog_hit;
  logic               to_hit;
  logic               fin_hit;

  assign cycles_nxt = (&cycles) ? cycles : cycles + CNT_W'(1);
  assign in_reset   = (state == ST_RESET);
  assign in_run     = (state == ST_RUN);
  assign in_active  = (state == ST_RUN) || (state == ST_DRAIN);

  // Triggers look at the count this edge produces, so a timeout of T
  // enters DRAIN on the edge that makes cycles_op equal to T.
  assign wdog_hit = |err_set_vec;
  assign to_hit   = (sim_ctrl_seq_timeout_ip != '0) &&
                    (cycles_nxt >= sim_ctrl_seq_timeout_ip);
  assign fin_hit  = sim_ctrl_seq_finish_req_ip || pend;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    sim_ctrl_seq_chan #(
      .IDX      (g),
      .CNT_W    (CNT_W),
      .RST_BASE (RST_BASE),
      .RST_STEP (RST_STEP),
      .SOFT_LEN (SOFT_LEN),
      .WDOG_W   (WDOG_W)
    ) u_chan (
      .clk        (sim_ctrl_seq_clk_ip),
      .rst_n      (sim_ctrl_seq_rst_n_ip),
      .in_reset   (in_reset),
      .in_run     (in_run),
      .in_active  (in_active),
      .cycles_nxt (cycles_nxt),
      .soft_req   (sim_ctrl_seq_soft_rst_ip[g]),
      .hbeat      (sim_ctrl_seq_hbeat_ip[g]),
      .wdog_lim   (sim_ctrl_seq_wdog_lim_ip),
      .rst        (rst_vec[g]),
      .wdog_err   (err_vec[g]),
      .err_set    (err_set_vec[g])
    );
  end

  always_ff @(posedge sim_ctrl_seq_clk_ip or negedge sim_ctrl_seq_rst_n_ip) begin
    if (!sim_ctrl_seq_rst_n_ip) begin
      state  <= ST_RESET;
      cause  <= CAUSE_NONE;
      finish <= 1'b0;
      cycles <= '0;
      dcnt   <= '0;
      pend   <= 1'b0;
    end else begin
      if (state != ST_DONE) begin
        cycles <= cycles_nxt;
      end
      case (state)
        ST_RESET: begin
          if (sim_ctrl_seq_finish_req_ip) begin
            pend <= 1'b1;
          end
          if (cycles_nxt >= REL_LAST) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (wdog_hit || to_hit || fin_hit) begin
            state <= ST_DRAIN;
            dcnt  <= DRAIN_LAST;
            if (wdog_hit) begin
              cause <= CAUSE_WDOG;
            end else if (to_hit) begin
              cause <= CAUSE_TIMEOUT;
            end else begin
              cause <= CAUSE_FINISH;
            end
          end
        end
        ST_DRAIN: begin
          if (dcnt == '0) begin
            state  <= ST_DONE;
            finish <= 1'b1;
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sim_ctrl_seq_rst_op      = rst_vec;
  assign sim_ctrl_seq_wdog_err_op = err_vec;
  assign sim_ctrl_seq_cycles_op   = cycles;
  assign sim_ctrl_seq_state_op    = state;
  assign sim_ctrl_seq_cause_op    = cause;
  assign sim_ctrl_seq_finish_op   = finish;

endmodule

// File: tb/tb_sim_ctrl_seq.sv
// Directed bench for sim_ctrl_seq: vector tables per scenario plus short
// hand-written sequences for soft reset and mid-DRAIN async reset.
module tb_sim_ctrl_seq;
  import sim_ctrl_seq_pkg::*;

  localparam int CH = 4;
  localparam int CW = 32;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] timeout = '0;
  logic [WW-1:0] wdog_lim = '0;
  logic [CH-1:0] soft_rst = '0;
  logic [CH-1:0] hbeat = '0;
  logic          finish_req = 1'b0;
  logic [CH-1:0] rst_o;
  logic [CW-1:0] cycles_o;
  logic [CH-1:0] err_o;
  logic [1:0]    state_o;
  logic [1:0]    cause_o;
  logic          finish_o;

  typedef struct {
    int            n;
    logic [1:0]    st;
    logic [1:0]    cause;
    logic          fin;
    logic [CW-1:0] cyc;
    logic [CH-1:0] rst;
    logic [CH-1:0] err;
  } vec_t;

  vec_t          tbl[$];
  logic [CH-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            n = 0;
  logic          hb_en = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL sim_timeout: got no end of test, required end before 500000");
    $fatal(1, "bench time limit");
  end

  sim_ctrl_seq dut (
    .sim_ctrl_seq_clk_ip        (clk),
    .sim_ctrl_seq_rst_n_ip      (rst_n),
    .sim_ctrl_seq_timeout_ip    (timeout),
    .sim_ctrl_seq_wdog_lim_ip   (wdog_lim),
    .sim_ctrl_seq_soft_rst_ip   (soft_rst),
    .sim_ctrl_seq_hbeat_ip      (hbeat),
    .sim_ctrl_seq_finish_req_ip (finish_req),
    .sim_ctrl_seq_rst_op        (rst_o),
    .sim_ctrl_seq_cycles_op     (cycles_o),
    .sim_ctrl_seq_wdog_err_op   (err_o),
    .sim_ctrl_seq_state_op      (state_o),
    .sim_ctrl_seq_cause_op      (cause_o),
    .sim_ctrl_seq_finish_op     (finish_o)
  );

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0h, required %0h", name, n, act, exp);
    end
  endtask

  // Channels 0-2 heartbeat on every 4th edge when enabled.
  task automatic tick();
    hbeat = (hb_en && (((n + 1) % 4) == 0)) ? 4'b0111 : 4'b0000;
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic do_reset(input int to, input int lim);
    rst_n      = 1'b0;
    soft_rst   = '0;
    hbeat      = '0;
    finish_req = 1'b0;
    hb_en      = 1'b0;
    timeout    = CW'(to);
    wdog_lim   = WW'(lim);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n     = 0;
  endtask

  function automatic vec_t mk(input int nn, input int st, input int cs, input int fin,
                              input int cyc, input int rs, input int er);
    vec_t v;
    v.n     = nn;
    v.st    = st[1:0];
    v.cause = cs[1:0];
    v.fin   = fin[0];
    v.cyc   = CW'(cyc);
    v.rst   = rs[CH-1:0];
    v.err   = er[CH-1:0];
    return v;
  endfunction

  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      while (n < tbl[i].n) tick();
      chk({tag, "_state"},  CW'(state_o),  CW'(tbl[i].st));
      chk({tag, "_cause"},  CW'(cause_o),  CW'(tbl[i].cause));
      chk({tag, "_finish"}, CW'(finish_o), CW'(tbl[i].fin));
      chk({tag, "_cycles"}, cycles_o,      tbl[i].cyc);
      chk({tag, "_rst"},    CW'(rst_o),    CW'(tbl[i].rst));
      chk({tag, "_err"},    CW'(err_o),    CW'(tbl[i].err));
    end
    tbl.delete();
  endtask

  // Staggered release 5/7/9/11, RUN from 11.
  task automatic load_release_tbl();
    tbl.push_back(mk(0,  0, 0, 0, 0,  4'b1111, 0));
    tbl.push_back(mk(4,  0, 0, 0, 4,  4'b1111, 0));
    tbl.push_back(mk(5,  0, 0, 0, 5,  4'b1110, 0));
    tbl.push_back(mk(6,  0, 0, 0, 6,  4'b1110, 0));
    tbl.push_back(mk(7,  0, 0, 0, 7,  4'b1100, 0));
    tbl.push_back(mk(9,  0, 0, 0, 9,  4'b1000, 0));
    tbl.push_back(mk(10, 0, 0, 0, 10, 4'b1000, 0));
    tbl.push_back(mk(11, 1, 0, 0, 11, 4'b0000, 0));
    tbl.push_back(mk(12, 1, 0, 0, 12, 4'b0000, 0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // A: defaults, timeout 0, then soft reset on channel 2 at edge 30.
    do_reset(0, 0);
    load_release_tbl();
    run_tbl("release");
    while (n < 29) tick();
    chk("soft_pre_rst", CW'(rst_o), CW'(4'b0000));
    soft_rst = 4'b0100;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0000);
    tick();
    soft_rst = '0;
    while (exp_q.size() > 0) begin
      logic [CH-1:0] e;
      e = exp_q.pop_front();
      chk("soft_rst_ch2", CW'(rst_o), CW'(e));
      if (exp_q.size() > 0) tick();
    end
    while (n < 1000) tick();
    tbl.push_back(mk(1000, 1, 0, 0, 1000, 0, 0));
    run_tbl("idle1000");

    // B: timeout 20.
    do_reset(20, 0);
    tbl.push_back(mk(19, 1, 0, 0, 19, 0, 0));
    tbl.push_back(mk(20, 2, 2, 0, 20, 0, 0));
    tbl.push_back(mk(23, 2, 2, 0, 23, 0, 0));
    tbl.push_back(mk(24, 3, 2, 1, 24, 0, 0));
    tbl.push_back(mk(40, 3, 2, 1, 24, 0, 0));
    run_tbl("timeout20");

    // C: watchdog limit 8, channel 3 silent.
    do_reset(0, 8);
    hb_en = 1'b1;
    tbl.push_back(mk(18, 1, 0, 0, 18, 0, 4'b0000));
    tbl.push_back(mk(19, 2, 3, 0, 19, 0, 4'b1000));
    tbl.push_back(mk(23, 3, 3, 1, 23, 0, 4'b1000));
    run_tbl("wdog8");

    // C2: watchdog and timeout on the same edge, all channels silent.
    do_reset(19, 8);
    tbl.push_back(mk(18, 1, 0, 0, 18, 0, 4'b0000));
    tbl.push_back(mk(19, 2, 3, 0, 19, 0, 4'b1111));
    run_tbl("wdog_vs_to");

    // D: finish request sampled on edge 3, while still in RESET.
    do_reset(0, 0);
    while (n < 2) tick();
    finish_req = 1'b1;
    tick();
    finish_req = 1'b0;
    tbl.push_back(mk(3,  0, 0, 0, 3,  4'b1111, 0));
    tbl.push_back(mk(11, 1, 0, 0, 11, 0, 0));
    tbl.push_back(mk(12, 2, 1, 0, 12, 0, 0));
    tbl.push_back(mk(15, 2, 1, 0, 15, 0, 0));
    tbl.push_back(mk(16, 3, 1, 1, 16, 0, 0));
    run_tbl("pend_fin");

    // E: timeout and finish request on the same edge.
    do_reset(15, 0);
    while (n < 14) tick();
    finish_req = 1'b1;
    tick();
    finish_req = 1'b0;
    tbl.push_back(mk(15, 2, 2, 0, 15, 0, 0));
    run_tbl("to_vs_fin");

    // F: async reset in DRAIN, then a fresh release sequence.
    do_reset(20, 0);
    while (n < 21) tick();
    chk("pre_arst_state", CW'(state_o), CW'(ST_DRAIN));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rst",    CW'(rst_o),    CW'(4'b1111));
    chk("arst_cycles", cycles_o,      CW'(0));
    chk("arst_err",    CW'(err_o),    CW'(0));
    chk("arst_state",  CW'(state_o),  CW'(ST_RESET));
    chk("arst_cause",  CW'(cause_o),  CW'(CAUSE_NONE));
    chk("arst_finish", CW'(finish_o), CW'(0));
    do_reset(0, 0);
    load_release_tbl();
    run_tbl("rerelease");

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
